// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multicycle signed multiply/divide engine owning HI/LO.
//               mult: 32 shift-add steps on magnitudes, then sign fix.
//               div : 32 restoring-divide steps on magnitudes, then sign fix.
//               Optional feature macro: MULTDIV_DIVZERO_TRAP_EN
//               (divide-by-zero detected at start, early done + div_zero).
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op;
    logic               r_neg_main;   // sign of product / quotient
    logic               r_neg_rem;    // sign of remainder (dividend sign)
    logic [WIDTH-1:0]   r_opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_acc_hi;     // partial product high / partial remainder
    logic [WIDTH-1:0]   r_acc_lo;     // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shl;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

`ifdef MULTDIV_DIVZERO_TRAP_EN
    logic               r_trap;
    logic               r_dz;
    logic               w_b_zero;
    assign w_b_zero = (b == '0);
    assign div_zero = r_dz;
`else
    assign div_zero = 1'b0;
`endif

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign done = r_done;
    assign busy = (r_state != S_IDLE);

    // Operand magnitudes; -2^(W-1) maps to itself, which is correct as unsigned.
    assign w_mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    // One shift-add step: add multiplicand when current multiplier bit is set.
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

    // One restoring-divide step: shift in next dividend bit, trial subtract.
    assign w_shl = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_ge  = (w_shl >= {1'b0, r_opnd});
    assign w_sub = w_shl[WIDTH-1:0] - r_opnd;

    // Two's-complement sign correction applied in FIX.
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_main ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fix  = r_neg_main ? (~r_acc_lo + 1'b1) : r_acc_lo;
    assign w_rem_fix  = r_neg_rem ? (~r_acc_hi + 1'b1) : r_acc_hi;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic: iterate 32 steps, then one fix-up cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = op ? S_DIV : S_MULT;
            S_MULT:  if (r_cnt == c_last_iter) w_state_nxt = S_FIX;
            S_DIV:   if (r_cnt == c_last_iter) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result commit to HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_op       <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_opnd     <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
`ifdef MULTDIV_DIVZERO_TRAP_EN
            r_trap     <= 1'b0;
            r_dz       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MULTDIV_DIVZERO_TRAP_EN
            r_dz   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op       <= op;
                        r_neg_main <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_rem  <= a[WIDTH-1];
                        r_cnt      <= '0;
                        r_acc_hi   <= '0;
                        if (op) begin
                            r_opnd   <= w_mag_b;
                            r_acc_lo <= w_mag_a;
                        end else begin
                            r_opnd   <= w_mag_a;
                            r_acc_lo <= w_mag_b;
                        end
`ifdef MULTDIV_DIVZERO_TRAP_EN
                        // Trap: preload the counter so DIV exits after one edge.
                        r_trap <= op && w_b_zero;
                        if (op && w_b_zero) r_cnt <= c_last_iter;
`endif
                    end
                end
                S_MULT: begin
                    r_acc_hi <= w_mul_sum[WIDTH:1];
                    r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_acc_hi <= w_ge ? w_sub : w_shl[WIDTH-1:0];
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    r_cnt  <= '0;
`ifdef MULTDIV_DIVZERO_TRAP_EN
                    if (r_trap) begin
                        r_dz   <= 1'b1;
                        r_trap <= 1'b0;
                    end else
`endif
                    if (r_op) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide engine for the MIPS-subset datapath. It executes the mult and div funct codes.
- The control FSM pulses start with an op select and the latched A/B register values. It then waits in a stall state until done, and later reads hi/lo for mfhi/mflo.
- The engine owns the HI/LO architectural registers.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- start  input  1  request pulse, sampled only while busy=0
- op  input  1  0 = mult (signed), 1 = div (signed)
- a  input  WIDTH  multiplicand / dividend (rs via A register)
- b  input  WIDTH  multiplier / divisor (rt via B register)
- hi  output  WIDTH  HI register: product[63:32] / remainder
- lo  output  WIDTH  LO register: product[31:0] / quotient
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- div_zero  output  1  divide-by-zero flag, valid with done

Behaviour:
- Reset (synchronous, active-high, clock clk): hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0. Reset mid-operation aborts the operation with no done pulse and clears hi/lo.
- States: IDLE, MULT, DIV, FIX.
- IDLE, start=1 sampled at edge E0:
  - Capture a, b, op.
  - Compute operand magnitudes and result sign: mult sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - busy=1; go to MULT or DIV.
- MULT: shift-add on magnitudes, one partial-product bit per cycle, 32 cycles (edges E1..E32), then go to FIX.
- DIV: restoring divide on magnitudes, one quotient bit per cycle, 32 cycles (edges E1..E32), then go to FIX.
- FIX, at edge E33:
  - Apply two's-complement sign correction.
  - mult: {hi,lo} = signed 64-bit product.
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - Assert done=1 and set busy=0; return to IDLE.
- Latency: done is high for exactly one cycle, 33 clocks after the start-sampling edge.
- hi/lo change only at the done edge (or reset); otherwise they hold, so mfhi/mflo may read them at any time.
- done falls at the next edge unconditionally.
- start while busy=1 is ignored; it is neither queued nor allowed to corrupt the operation.
- start=1 during the done cycle (busy=0) is accepted as a new operation. The first result in hi/lo stays until the second done.
- op, a, b are don't-care except at the sampling edge.
- Width/overflow rules:
  - -2^31 / -1: lo=32'h80000000, hi=0; no flag.
  - mult is a full 64-bit product, so it never overflows.

Optional Feature:
- Macro: MULTDIV_DIVZERO_TRAP_EN.
- Defined:
  - div with b==0 is detected at the sampling edge and skips the iterations.
  - done and div_zero pulse together at E2.
  - hi/lo remain unchanged.
  - The control unit may vector to its exception path.
- Undefined:
  - div_zero is tied 0.
  - div by zero runs the full 33 cycles with natural restoring results: lo = 32'hFFFFFFFF if a>=0, else 32'h00000001; hi = a.

Test Plan:
- mult a=7, b=-3 -> done at 33 clocks after start; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high exactly 33 cycles.
- mult a=32'h80000000, b=32'h80000000 -> hi=32'h40000000, lo=0; div a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- div a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0, div_zero=0.
- start pulses every cycle during a mult 5x6 -> single done, hi=0, lo=30. A new start in the done cycle (div 100/7) -> second done 33 cycles later, lo=14, hi=2.
- reset asserted at cycle 15 of an operation -> no done, hi=lo=0, busy=0. start two cycles later -> normal completion.
- div a=9, b=0:
  - with MULTDIV_DIVZERO_TRAP_EN: done+div_zero at E2, hi/lo unchanged.
  - without: done at 33 clocks after start, lo=32'hFFFFFFFF, hi=9.
